mic_array_emulator: RTL

// Emulates the 32-line microphone array seen by the mic capture block. Takes the capture

---
 rtl/mic_array_emulator.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mic_array_emulator.sv
// mic_array_emulator: emulates a 32-line serial microphone array for bring-up and loopback.
// mic_clock / mic_select are resynchronized into clk. Each select edge loads one 16-bit word
// per line into a per-lane shifter. After LEAD_BITS falling edges, the word is shifted out MSB first.
// Optional build macro MIC_EMU_LFSR_EN adds the LFSR pattern generator used by MODE 2.

module mic_emu_lane #(
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 zero,
  input  logic [WORD_BITS-1:0] word,
  output logic                 dout
);
  logic [WORD_BITS-1:0] sreg;

  // load beats everything (select edge wins); zero masks the pin; shift emits the MSB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg <= '0;
      dout <= 1'b0;
    end else if (load) begin
      sreg <= word;
      dout <= 1'b0;
    end else if (zero) begin
      dout <= 1'b0;
    end else if (shift) begin
      dout <= sreg[WORD_BITS-1];
      sreg <= {sreg[WORD_BITS-2:0], 1'b0};
    end
  end
endmodule

module mic_array_emulator #(
  parameter int LEAD_BITS = 5,
  parameter int WORD_BITS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        slave_chip_select_n,
  input  logic [1:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        mic_clock,
  input  logic        mic_select,
  output logic [31:0] mic_data
);
  localparam int NUM_LANES = 32;
  localparam int BIT_MAX   = LEAD_BITS + WORD_BITS;
  localparam int BW        = $clog2(BIT_MAX + 1);
  localparam logic [BW-1:0] LEAD_V = BW'(LEAD_BITS);
  localparam logic [BW-1:0] MAX_V  = BW'(BIT_MAX);

  // [0] = first sync stage, [1] = synchronized, [2] = previous (edge detect)
  logic [2:0] mclk_sr, msel_sr;
  logic       clk_fall, sel_sync, sel_edge, sel_rise;

  logic        en;
  logic [1:0]  mode;
  logic [15:0] const_reg, frame_cnt, short_cnt, frame_nxt, fc_word;
  logic        active;
  logic [BW-1:0] bit_idx;
  logic        wr, rd, en_rise_wr, in_range, load, shift, zero;
  logic [NUM_LANES-1:0][WORD_BITS-1:0] words;

  // 2-FF synchronizers plus an edge-detect stage for both mic pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mclk_sr <= '0;
      msel_sr <= '0;
    end else begin
      mclk_sr <= {mclk_sr[1:0], mic_clock};
      msel_sr <= {msel_sr[1:0], mic_select};
    end
  end

  assign clk_fall = mclk_sr[2] & ~mclk_sr[1];
  assign sel_sync = msel_sr[1];
  assign sel_edge = msel_sr[2] ^ msel_sr[1];
  assign sel_rise = msel_sr[1] & ~msel_sr[2];

  assign wr         = ~slave_chip_select_n & slave_write;
  assign rd         = ~slave_chip_select_n & slave_read;
  assign en_rise_wr = wr && (slave_address == 2'd0) && slave_writedata[0] && !en;

  // bit_idx counts falling edges since the select edge; data window is [LEAD, LEAD+16)
  assign in_range = (bit_idx >= LEAD_V) && (bit_idx < MAX_V);
  assign load     = en & sel_edge;
  assign shift    = en & active & clk_fall & ~sel_edge & in_range;
  // nothing leaves the pins until the first select edge after enable
  assign zero     = ~en | ~active | (clk_fall & ~in_range);

  // a rising select edge opens a new frame, so its words already carry the new count
  assign frame_nxt = frame_cnt + 16'd1;
  assign fc_word   = sel_rise ? frame_nxt : frame_cnt;

`ifdef MIC_EMU_LFSR_EN
  logic [15:0] lfsr;

  // Galois x^16+x^14+x^13+x^11+1, one step per half-frame while enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lfsr <= 16'hACE1;
    else if (en_rise_wr)
      lfsr <= 16'hACE1;
    else if (en && sel_edge)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
`endif

  // registers, frame / short counters and the half-frame bit position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en        <= 1'b0;
      mode      <= 2'd0;
      const_reg <= '0;
      frame_cnt <= '0;
      short_cnt <= '0;
      active    <= 1'b0;
      bit_idx   <= '0;
    end else begin
      if (wr && slave_address == 2'd0) begin
        en   <= slave_writedata[0];
        mode <= slave_writedata[2:1];
      end
      if (wr && slave_address == 2'd1)
        const_reg <= slave_writedata[15:0];
      if (en_rise_wr) begin
        frame_cnt <= '0;
        short_cnt <= '0;
        active    <= 1'b0;
      end else if (en) begin
        if (sel_edge) begin
          bit_idx <= '0;
          active  <= 1'b1;
          if (sel_rise)
            frame_cnt <= frame_nxt;
          // only a half-frame that was actually being driven can be short
          if (active && bit_idx < MAX_V && short_cnt != 16'hFFFF)
            short_cnt <= short_cnt + 16'd1;
        end else if (clk_fall && bit_idx < MAX_V) begin
          bit_idx <= bit_idx + 1'b1;
        end
      end
      // a write to SHORT clears it even against a same-cycle increment
      if (wr && slave_address == 2'd3)
        short_cnt <= '0;
    end
  end

  // registered read mux, one-cycle latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      slave_readdata <= '0;
    else if (rd) begin
      case (slave_address)
        2'd0:    slave_readdata <= {29'b0, mode, en};
        2'd1:    slave_readdata <= {16'b0, const_reg};
        2'd2:    slave_readdata <= {16'b0, frame_cnt};
        default: slave_readdata <= {16'b0, short_cnt};
      endcase
    end
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    logic [5:0] ch;
    // select low carries the odd channel of the pair
    assign ch = {5'(j), ~sel_sync};

    // pattern select; reserved mode (and MODE 2 without the LFSR) fall back to the counter
    always_comb begin
      words[j] = {fc_word[9:0], ch};
      case (mode)
        2'd1: words[j] = const_reg;
`ifdef MIC_EMU_LFSR_EN
        2'd2: words[j] = lfsr ^ {10'b0, ch};
`endif
        default: ;
      endcase
    end

    mic_emu_lane #(.WORD_BITS(WORD_BITS)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .shift   (shift),
      .zero    (zero),
      .word    (words[j]),
      .dout    (mic_data[j])
    );
  end

  logic unused_bits;
  assign unused_bits = ^{slave_writedata[31:16], fc_word[15:10], mclk_sr[0], msel_sr[0]};

endmodule
